wordcount_accum_array: RTL and testbench
========================================

# wordcount_accum_array

Per-key occurrence accumulator for the wordcount pipeline, sitting directly downstream of the search-and-add controller. It consumes the `accum_addr`/`accum_din`/`accum_we` update stream, performs `mem[addr] += din` through a pipelined read-modify-write with full hazard forwarding, and on request drains the whole table as a 512-bit AXI4-Stream toward the AXI write master, optionally clearing entries as they are read.

## Interface
- `ADDR_WIDTH`, default 10: table depth is DEPTH = 2^ADDR_WIDTH 64-bit entries; minimum 3.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `ready`  out  1  high once the post-reset init sweep completes.
- `accum_addr`  in  32  entry index; bits above ADDR_WIDTH must be zero.
- `accum_din`  in  64  increment value.
- `accum_we`  in  1  update strobe, one update per cycle, no backpressure.
- `drain_kick`  in  1  start a drain; ignored unless idle and `ready`.
- `drain_clear`  in  1  sampled with `drain_kick`; 1 means zero each entry after reading it.
- `drain_busy`  out  1  high from the cycle after an accepted kick until the last beat is accepted.
- `m_axis_tvalid`  out  1  drain beat valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tdata`  out  512  8 entries per beat.
- `m_axis_tlast`  out  1  last beat of a drain.
- `drop_count`  out  32  number of discarded updates; saturates at 2^32-1.

## Operation
- **Reset behaviour**
  - All outputs reset to 0.
  - After reset, an INIT sweep writes 0 to entries 0..DEPTH-1, one per cycle. `ready` rises the cycle after the last write.
- **Update pipeline**
  - S0 registers the inputs. S1 issues the synchronous RAM read. S2 selects the operand and computes the sum. S3 writes back.
  - S2 operand comes from the youngest in-flight or just-completed write to the same address, otherwise from RAM data. Consecutive same-address updates must yield exact totals.
- **Dropped updates**: an update is discarded and `drop_count` increments when any of these holds while `accum_we` is high:
  - `ready` is 0;
  - the address is out of range (upper bits nonzero);
  - `drain_busy` is 1.
- **Drain state machine**
  - IDLE -> FLUSH on an accepted kick. FLUSH waits until S0..S3 are empty (at most 4 cycles).
  - READ reads 8 consecutive entries into a beat register. If `drain_clear` was sampled high, it writes 0 to each entry after reading it.
  - SEND presents the beat; on `tvalid && tready` it goes to READ, or to IDLE after beat DEPTH/8-1.
- **Beat layout**: beat k carries entry 8k+j in bits [64j+63:64j].
- **Drain restrictions**: a kick while `drain_busy` or while not `ready` is ignored. `drain_kick` does not count toward `drop_count`.
- **Reset mid-drain**: the drain aborts immediately, `tvalid` falls at the reset edge, and a new INIT sweep runs.

## Timing
- **Update visibility**: an update sampled at edge t is committed to RAM at edge t+4. A drain started afterwards always observes it, because FLUSH guarantees this.
- **Throughput**: one update per cycle sustained, with no bubbles for address collisions.
- **Drain timing**
  - First `tvalid` no earlier than 6 cycles after the accepted kick (1 IDLE, up to 4 FLUSH, plus READ).
  - Beats are spaced at least READ length apart; READ may prefetch during SEND.
- **AXI-Stream rules**
  - `tdata`/`tlast` stay stable while `tvalid && !tready`.
  - `tvalid` never drops without a handshake, except on reset.
- **Arithmetic**: 64-bit unsigned; overflow behaviour is set under Configuration.
- `drop_count` never wraps.

## Configuration
- **`WORDCOUNT_ACCUM_SATURATE_EN` defined**: S2 sums clamp at 2^64-1, and entries at the maximum stay at the maximum.
- **Not defined**: sums wrap modulo 2^64.
- No other behaviour differs between the two builds.

## Test plan
- **Init**: reset, then wait. `ready` rises exactly DEPTH+1 cycles after reset deasserts. A drain then returns DEPTH/8 all-zero beats, with `tlast` only on the last beat.
- **Collisions**: 16 consecutive cycles of addr=5, din=1, then addr=5 din=3 and addr=6 din=7 alternating for 8 cycles. Drain: entry5=28, entry6=28, entry8k+j layout verified.
- **Backpressure and clear**: drain with `drain_clear`=1 while toggling `tready` pseudo-randomly. Data stays stable while stalled and matches the model. A second drain returns all zeros.
- **Drops**: send updates to addr=2^ADDR_WIDTH, before `ready`, and during `drain_busy` (3 of each). `drop_count`=9 and the table is unchanged.
- **Overflow**: two updates of din=2^63 to one address. Entry reads 2^64-1 with the macro defined, 0 without.
- **Reset mid-drain**: reset asserted on the third beat. `tvalid`=0 the next cycle, the INIT sweep reruns, and a following drain returns all zeros.

Source files
------------

// File: rtl/wordcount_accum_array.sv
// wordcount_accum_array
// Per-key occurrence accumulator. Performs mem[addr] += din through a
// 4-stage read-modify-write pipeline (S0 register, S1 RAM read, S2 add,
// S3 write back) with forwarding, and drains the table as 512-bit
// AXI4-Stream beats (8 entries per beat), optionally zeroing entries as
// they are read.
//
// Build option: define WORDCOUNT_ACCUM_SATURATE_EN to clamp sums at
// 2^64-1; otherwise sums wrap modulo 2^64.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ready               high once the post-reset zeroing sweep is done
//   accum_addr/din/we   update stream, one update per cycle
//   drain_kick/clear    start a drain (clear = zero entries after read)
//   drain_busy          drain in progress
//   m_axis_*            drain stream toward the AXI write master
//   drop_count          saturating count of discarded updates
module wordcount_accum_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic         clk,
  input  logic         reset,
  output logic         ready,
  input  logic [31:0]  accum_addr,
  input  logic [63:0]  accum_din,
  input  logic         accum_we,
  input  logic         drain_kick,
  input  logic         drain_clear,
  output logic         drain_busy,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [511:0] m_axis_tdata,
  output logic         m_axis_tlast,
  output logic [31:0]  drop_count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_FLUSH, ST_READ, ST_SEND} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]   r_init_addr;   // top bit set = sweep finished
  logic [ADDR_WIDTH-1:0] r_base;        // first entry of current beat
  logic [3:0]            r_rd_cnt;
  logic                  r_clear;
  logic [7:0][63:0]      r_beat;
  logic                  r_ready;
  logic [31:0]           r_drop_count;

  // valid shift register: bits 0..3 are S0..S3, bit 4 is the write that
  // completed at the last edge (kept only for forwarding)
  logic [4:0]            r_vld_pipe;
  logic [ADDR_WIDTH-1:0] r_s0_addr, r_s1_addr, r_s2_addr, r_s3_addr, r_s4_addr;
  logic [63:0]           r_s0_din, r_s1_din, r_s2_din, r_s3_sum, r_s4_sum;

  logic [63:0]           r_mem [DEPTH];
  logic [63:0]           r_ram_q;

  logic                  w_busy, w_oor, w_accept, w_last;
  logic [ADDR_WIDTH-1:0] w_rd_addr, w_wa;
  logic                  w_we;
  logic [63:0]           w_wd, w_op, w_sum;

  assign w_busy   = (r_state == ST_FLUSH) || (r_state == ST_READ) || (r_state == ST_SEND);
  assign w_oor    = |accum_addr[31:ADDR_WIDTH];
  assign w_accept = accum_we && r_ready && !w_oor && !w_busy;
  assign w_last   = (r_base == ADDR_WIDTH'(DEPTH - 8));

  // ---------------- update pipeline ----------------
  always_ff @(posedge clk) begin
    if (reset) r_vld_pipe <= '0;
    else       r_vld_pipe <= {r_vld_pipe[3:0], w_accept};
    r_s0_addr <= accum_addr[ADDR_WIDTH-1:0];
    r_s0_din  <= accum_din;
    r_s1_addr <= r_s0_addr;
    r_s1_din  <= r_s0_din;
    r_s2_addr <= r_s1_addr;
    r_s2_din  <= r_s1_din;
    r_s3_addr <= r_s2_addr;
    r_s3_sum  <= w_sum;
    r_s4_addr <= r_s3_addr;
    r_s4_sum  <= r_s3_sum;
  end

  // The RAM read for S2 happened before the S3 write and concurrently
  // with the S4 write, so both may hold newer data than r_ram_q.
  always_comb begin
    if (r_vld_pipe[3] && r_s3_addr == r_s2_addr)      w_op = r_s3_sum;
    else if (r_vld_pipe[4] && r_s4_addr == r_s2_addr) w_op = r_s4_sum;
    else                                              w_op = r_ram_q;
  end

`ifdef WORDCOUNT_ACCUM_SATURATE_EN
  logic [64:0] w_sum_full;
  assign w_sum_full = {1'b0, w_op} + {1'b0, r_s2_din};
  assign w_sum      = w_sum_full[64] ? '1 : w_sum_full[63:0];
`else
  assign w_sum = w_op + r_s2_din;
`endif

  // ---------------- RAM (read-first, one read, one write port) --------
  assign w_rd_addr = (r_state == ST_READ) ? r_base + ADDR_WIDTH'(r_rd_cnt[2:0]) : r_s1_addr;

  // Writers never overlap: INIT and drain only run with the pipeline empty.
  always_comb begin
    w_we = 1'b0;
    w_wa = r_s3_addr;
    w_wd = r_s3_sum;
    if (r_state == ST_INIT) begin
      w_we = !r_init_addr[ADDR_WIDTH];
      w_wa = r_init_addr[ADDR_WIDTH-1:0];
      w_wd = '0;
    end else if (r_state == ST_READ) begin
      w_we = r_clear && (r_rd_cnt < 4'd8);
      w_wa = w_rd_addr;
      w_wd = '0;
    end else begin
      w_we = r_vld_pipe[3];
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wa] <= w_wd;
    r_ram_q <= r_mem[w_rd_addr];
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (r_init_addr[ADDR_WIDTH]) w_state_nxt = ST_IDLE;
      ST_IDLE:  if (drain_kick && r_ready) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_vld_pipe[3:0] == 4'b0) w_state_nxt = ST_READ;
      ST_READ:  if (r_rd_cnt == 4'd8) w_state_nxt = ST_SEND;
      ST_SEND:  if (m_axis_tready) w_state_nxt = w_last ? ST_IDLE : ST_READ;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_addr  <= '0;
      r_ready      <= 1'b0;
      r_base       <= '0;
      r_rd_cnt     <= '0;
      r_clear      <= 1'b0;
      r_beat       <= '0;
      r_drop_count <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        if (r_init_addr[ADDR_WIDTH]) r_ready <= 1'b1;
        else r_init_addr <= r_init_addr + (ADDR_WIDTH+1)'(1);
      end
      if (r_state == ST_IDLE && drain_kick && r_ready) begin
        r_clear  <= drain_clear;
        r_base   <= '0;
        r_rd_cnt <= '0;
      end
      if (r_state == ST_READ) begin
        r_rd_cnt <= r_rd_cnt + 4'd1;
        // RAM data lags the issued address by one cycle
        if (r_rd_cnt != 4'd0) r_beat[r_rd_cnt[2:0] - 3'd1] <= r_ram_q;
      end
      if (r_state == ST_SEND && m_axis_tready) begin
        r_base   <= r_base + ADDR_WIDTH'(8);
        r_rd_cnt <= '0;
      end
      if (accum_we && !w_accept && r_drop_count != '1)
        r_drop_count <= r_drop_count + 32'd1;
    end
  end

  assign ready         = r_ready;
  assign drain_busy    = w_busy;
  assign m_axis_tvalid = (r_state == ST_SEND);
  assign m_axis_tlast  = (r_state == ST_SEND) && w_last;
  assign m_axis_tdata  = r_beat;
  assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_wordcount_accum_array.sv
// Self-checking bench for wordcount_accum_array (ADDR_WIDTH=5, 4 beats/drain).
module tb_wordcount_accum_array;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;
  localparam int NBEAT = DEPTH / 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ready;
  logic [31:0]  accum_addr = '0;
  logic [63:0]  accum_din = '0;
  logic         accum_we = 1'b0;
  logic         drain_kick = 1'b0;
  logic         drain_clear = 1'b0;
  logic         drain_busy;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic [511:0] m_axis_tdata;
  logic         m_axis_tlast;
  logic [31:0]  drop_count;

  wordcount_accum_array #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .accum_addr(accum_addr), .accum_din(accum_din), .accum_we(accum_we),
    .drain_kick(drain_kick), .drain_clear(drain_clear), .drain_busy(drain_busy),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] model   [DEPTH];
  logic [63:0] drained [DEPTH];

  typedef struct {
    logic [31:0] addr;
    logic [63:0] din;
    logic [31:0] exp_drops;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] add_m(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef WORDCOUNT_ACCUM_SATURATE_EN
    return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
`else
    return s[63:0];
`endif
  endfunction

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // drive one in-range accepted update for a single cycle (we left high)
  task automatic upd(input int a, input logic [63:0] d);
    accum_we = 1'b1; accum_addr = a; accum_din = d;
    model[a] = add_m(model[a], d);
    @(negedge clk);
  endtask

  // Releases reset (called at a negedge) and measures cycles until ready.
  // The first ndrop cycles carry updates that must be dropped.
  task automatic init_wait(input string nm, input int ndrop);
    int cyc;
    cyc = 0;
    reset = 1'b0;
    while (!ready && cyc < 500) begin
      if (cyc < ndrop) begin accum_we = 1'b1; accum_addr = 1; accum_din = 100; end
      else accum_we = 1'b0;
      @(negedge clk); cyc++;
    end
    accum_we = 1'b0;
    chk(nm, cyc, DEPTH + 1);
  endtask

  task automatic drain(input bit clr, input bit rnd, input bit busy_drops);
    logic [511:0] held;
    bit stalled;
    int beats, cyc;
    drain_kick = 1'b1; drain_clear = clr;
    @(negedge clk);
    drain_kick = 1'b0; drain_clear = 1'b0;
    chk("busy_after_kick", drain_busy, 1'b1);
    if (busy_drops) begin
      for (int i = 0; i < 3; i++) begin
        accum_we = 1'b1; accum_addr = 3; accum_din = 50;
        @(negedge clk);
      end
      accum_we = 1'b0;
    end
    beats = 0; stalled = 0; cyc = 0;
    while (beats < NBEAT && cyc < 2000) begin
      if (stalled) begin
        chk("tvalid_held", m_axis_tvalid, 1'b1);
        chk("tdata_stable", m_axis_tdata, held);
      end
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          chk("tlast", m_axis_tlast, 1'(beats == NBEAT - 1));
          for (int j = 0; j < 8; j++) begin
            drained[8*beats+j] = m_axis_tdata[64*j +: 64];
            chk($sformatf("entry%0d", 8*beats+j), m_axis_tdata[64*j +: 64], model[8*beats+j]);
          end
          beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = m_axis_tdata;
        end
      end
      @(negedge clk); cyc++;
    end
    m_axis_tready = 1'b0;
    chk("drain_beats", beats, NBEAT);
    chk("busy_after_drain", drain_busy, 1'b0);
    if (clr) model_zero();
  endtask

  initial begin
    int nb, cyc;
    tbl[0] = '{32'd0,          64'd10,     32'd3};
    tbl[1] = '{32'd31,         64'd5,      32'd3};
    tbl[2] = '{32'd32,         64'd1,      32'd4};
    tbl[3] = '{32'd9,          64'd2,      32'd4};
    tbl[4] = '{32'd9,          64'd3,      32'd4};
    tbl[5] = '{32'd32,         64'd9,      32'd5};
    tbl[6] = '{32'd9,          64'd4,      32'd5};
    tbl[7] = '{32'h8000_0020,  64'd1,      32'd6};
    tbl[8] = '{32'd16,         64'h1234,   32'd6};
    model_zero();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_busy", drain_busy, 1'b0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_drops", drop_count, 32'd0);

    // init sweep with 3 updates dropped before ready
    init_wait("ready_latency", 3);
    chk("drops_before_ready", drop_count, 32'd3);
    drain(1'b0, 1'b0, 1'b0);

    // table: mixed in-range / out-of-range updates back to back
    for (int i = 0; i < 9; i++) begin
      accum_we = 1'b1; accum_addr = tbl[i].addr; accum_din = tbl[i].din;
      if (tbl[i].addr < DEPTH) model[tbl[i].addr] = add_m(model[tbl[i].addr], tbl[i].din);
      @(negedge clk);
      chk($sformatf("tbl%0d_drops", i), drop_count, tbl[i].exp_drops);
    end
    // collisions
    for (int i = 0; i < 16; i++) upd(5, 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) upd(5, 64'd3);
      else            upd(6, 64'd7);
    end
    accum_we = 1'b0;
    drain(1'b0, 1'b0, 1'b1);
    chk("coll_entry5", drained[5], 64'd28);
    chk("coll_entry6", drained[6], 64'd28);
    chk("tbl_entry9", drained[9], 64'd9);
    chk("tbl_entry0", drained[0], 64'd10);
    chk("tbl_entry31", drained[31], 64'd5);
    chk("busy_drop_entry3", drained[3], 64'd0);
    chk("drops_total", drop_count, 32'd9);

    // backpressure with clear, then confirm everything is zero
    drain(1'b1, 1'b1, 1'b0);
    drain(1'b0, 1'b1, 1'b0);
    chk("cleared_entry5", drained[5], 64'd0);

    // overflow
    upd(12, 64'h8000_0000_0000_0000);
    upd(12, 64'h8000_0000_0000_0000);
    accum_we = 1'b0;
    drain(1'b0, 1'b0, 1'b0);
`ifdef WORDCOUNT_ACCUM_SATURATE_EN
    chk("overflow_entry12", drained[12], 64'hFFFF_FFFF_FFFF_FFFF);
`else
    chk("overflow_entry12", drained[12], 64'd0);
`endif

    // reset during the third beat
    drain_kick = 1'b1; drain_clear = 1'b0;
    @(negedge clk);
    drain_kick = 1'b0;
    m_axis_tready = 1'b1;
    nb = 0; cyc = 0;
    while (cyc < 1000) begin
      if (m_axis_tvalid) begin
        nb++;
        if (nb == 3) break;
      end
      @(negedge clk); cyc++;
    end
    chk("mid_third_beat", nb, 3);
    reset = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    chk("mid_tvalid_drop", m_axis_tvalid, 1'b0);
    chk("mid_busy_drop", drain_busy, 1'b0);
    chk("mid_ready_drop", ready, 1'b0);
    init_wait("reinit_latency", 0);
    model_zero();
    drain(1'b0, 1'b0, 1'b0);
    chk("reinit_entry12", drained[12], 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
